instr_encoder_loader: RTL

- Inverse of the CPU control/decode path: accepts symbolic instruction requests (kind, rd, rs1, rs2, imm) over a valid/ready handshake.
- Encodes each request into the RV32I 32-bit word that the control decoder expects.
- Streams the words sequentially into the instruction-memory write port.
- Used by the test harness and boot loader to build programs in instruction ROM/RAM without an external assembler.

---
 rtl/instr_pkg.sv | 48 ++++
 rtl/instr_encode.sv | 78 +++++++
 rtl/instr_encoder_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Instruction kinds, RV32I field constants and the NOP word shared by the
// encoder and the program loader.
package instr_pkg;

   typedef enum logic [3:0] {
      K_LW   = 4'd0,
      K_SW   = 4'd1,
      K_ADD  = 4'd2,
      K_SUB  = 4'd3,
      K_AND  = 4'd4,
      K_OR   = 4'd5,
      K_SLT  = 4'd6,
      K_ADDI = 4'd7,
      K_BEQ  = 4'd8,
      K_BNE  = 4'd9,
      K_JAL  = 4'd10
   } instr_kind_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   function automatic logic fits_signed(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [31:0] s;
      s = $signed(v) >>> (w - 1);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder: (kind, regs, imm) -> (word, bad).
// Immediate range checking is compiled in with IMM_RANGE_CHECK_EN.
module instr_encode
   import instr_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        bad
);

   logic [31:0] raw;
   logic        unk;
   logic        rng_bad;

   always_comb begin
      raw = NOP_WORD;
      unk = 1'b0;
      case (kind)
         K_LW:
            raw = {imm[11:0], rs1, F3_W, rd, OP_LOAD};
         K_SW:
            raw = {imm[11:5], rs2, rs1, F3_W,
                   imm[4:0], OP_STORE};
         K_ADD:
            raw = {F7_BASE, rs2, rs1, F3_ADD, rd, OP_RTYPE};
         K_SUB:
            raw = {F7_SUB, rs2, rs1, F3_ADD, rd, OP_RTYPE};
         K_AND:
            raw = {F7_BASE, rs2, rs1, F3_AND, rd, OP_RTYPE};
         K_OR:
            raw = {F7_BASE, rs2, rs1, F3_OR, rd, OP_RTYPE};
         K_SLT:
            raw = {F7_BASE, rs2, rs1, F3_SLT, rd, OP_RTYPE};
         K_ADDI:
            raw = {imm[11:0], rs1, F3_ADD, rd, OP_IMM};
         K_BEQ:
            raw = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                   imm[4:1], imm[11], OP_BRANCH};
         K_BNE:
            raw = {imm[12], imm[10:5], rs2, rs1, F3_BNE,
                   imm[4:1], imm[11], OP_BRANCH};
         K_JAL:
            raw = {imm[20], imm[10:1], imm[11],
                   imm[19:12], rd, OP_JAL};
         default:
            unk = 1'b1;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   always_comb begin
      rng_bad = 1'b0;
      case (kind)
         K_LW, K_SW, K_ADDI:
            rng_bad = !fits_signed(imm, 12);
         K_BEQ, K_BNE:
            rng_bad = !fits_signed(imm, 13) || imm[0];
         K_JAL:
            rng_bad = !fits_signed(imm, 21) || imm[0];
         default:
            rng_bad = 1'b0;
      endcase
   end
`else
   // Out-of-range immediates are truncated into the field.
   logic unused_imm;
   assign unused_imm = ^imm[31:21];
   assign rng_bad = 1'b0;
`endif

   assign bad  = unk || rng_bad;
   assign word = bad ? NOP_WORD : raw;

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded RV32I words into instruction memory from a valid/ready
// request stream. Optional immediate range check: IMM_RANGE_CHECK_EN.
module instr_encoder_loader
   import instr_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'hBFC0_0000,
   parameter int DEPTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_kind,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [31:0]           in_imm,
   input  logic                  in_last,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_FLUSH, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  err_q, err_d;

   logic [31:0] enc_word;
   logic        enc_bad;
   logic [CW-1:0] pend;

   instr_encode u_enc (
      .kind (in_kind),
      .rd   (in_rd),
      .rs1  (in_rs1),
      .rs2  (in_rs2),
      .imm  (in_imm),
      .word (enc_word),
      .bad  (enc_bad)
   );

   // A word in its write cycle is not yet in count_q but occupies a slot.
   assign pend = count_q + CW'(we_q);

   always_comb begin
      state_d  = state_q;
      we_d     = 1'b0;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      count_d  = count_q;
      err_d    = err_q;
      in_ready = 1'b0;
      if (we_q) begin
         addr_d  = addr_q + ADDR_WIDTH'(4);
         count_d = count_q + CW'(1);
      end
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               count_d = '0;
               err_d   = 1'b0;
               addr_d  = BASE_ADDR;
            end
         end
         S_LOAD: begin
            in_ready = (pend < CW'(DEPTH));
            if (in_valid && in_ready) begin
               we_d    = 1'b1;
               wdata_d = enc_word;
               if (enc_bad) err_d = 1'b1;
               if (in_last) state_d = S_FLUSH;
            end else if (in_valid && in_last) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         wdata_q <= '0;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign count     = count_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

endmodule
